// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port SRAM between instruction fetch (IF)
// and load/store (MEM). MEM normally wins; IF gets forced priority after
// STARVE_LIMIT consecutive MEM wins while it waits. Each transfer runs
// IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE, with a one-cycle ready pulse in
// DONE to the owner of the transfer.
// Optional feature: define ARB_PERF_CNT_EN to enable the two saturating
// stall counters; otherwise perf_if_stall / perf_mem_stall read 0.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  sram_we_n,
    output logic                  sram_oe_n,
    output logic [31:0]           perf_if_stall,
    output logic [31:0]           perf_mem_stall
);

    // Counter widths: wait counter holds WAIT_CYCLES-1, starve counter holds STARVE_LIMIT.
    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LOAD  = WCW'(WAIT_CYCLES - 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [SCW-1:0]        starve_cnt_q, starve_cnt_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;

    logic mem_any;
    logic if_starved;
    logic grant_mem;

    // A simultaneous load and store request is a single store request.
    assign mem_any    = mem_r_en | mem_w_en;
    assign if_starved = if_req && (starve_cnt_q == STARVE_MAX);

    // Next-state logic: arbitration in IDLE, wait countdown in ACCESS, one-cycle DONE.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        grant_mem    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || mem_any) begin
                    // MEM holds the older instruction, so it wins unless IF is starved.
                    grant_mem  = mem_any && !if_starved;
                    owner_d    = grant_mem ? OWNER_MEM : OWNER_IF;
                    addr_d     = grant_mem ? mem_addr : if_addr;
                    wdata_d    = mem_wdata;
                    write_d    = grant_mem && mem_w_en;
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = ST_ACCESS;
                end
                // Starvation only accumulates while IF is actually waiting.
                if (!if_req) begin
                    starve_cnt_d = '0;
                end else if (grant_mem) begin
                    if (starve_cnt_q != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + SCW'(1);
                    end
                end else begin
                    starve_cnt_d = '0;
                end
            end
            ST_ACCESS: begin
                if (wait_cnt_q == '0) begin
                    // Read data is valid from the SRAM in the last access cycle.
                    if (!write_q) begin
                        if (owner_q == OWNER_MEM) begin
                            mem_rdata_d = sram_rdata;
                        end else begin
                            if_rdata_d = sram_rdata;
                        end
                    end
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - WCW'(1);
                end
            end
            ST_DONE: begin
                // Forces at least one IDLE cycle between transfers.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_IF;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    // SRAM side is driven straight from the latched transfer, so it is stable
    // for the whole access; byte offset bits are dropped to form the word address.
    assign sram_addr  = addr_q >> 2;
    assign sram_wdata = wdata_q;
    assign sram_oe_n  = !((state_q == ST_ACCESS) && !write_q);
    assign sram_we_n  = !((state_q == ST_ACCESS) && write_q);

    assign if_ready  = (state_q == ST_DONE) && (owner_q == OWNER_IF);
    assign mem_ready = (state_q == ST_DONE) && (owner_q == OWNER_MEM);
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

`ifdef ARB_PERF_CNT_EN
    // Index 0 counts IF wait cycles, index 1 counts MEM wait cycles.
    logic [1:0] stall_ev;
    assign stall_ev[0] = if_req & ~if_ready;
    assign stall_ev[1] = mem_any & ~mem_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            logic [31:0] cnt_q, cnt_d;

            // Saturating increment on every stalled cycle.
            always_comb begin
                cnt_d = cnt_q;
                if (stall_ev[gi] && (cnt_q != 32'hFFFF_FFFF)) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            // Counter register, cleared by reset.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign perf_if_stall  = g_perf[0].cnt_q;
    assign perf_mem_stall = g_perf[1].cnt_q;
`else
    assign perf_if_stall  = 32'd0;
    assign perf_mem_stall = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// requests, all checked every cycle against a transaction-level reference
// model (grant time + fixed latency, expected memory image, starvation count).
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int WAIT  = 2;
    localparam int SL    = 3;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          mem_r_en;
    logic          mem_w_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          sram_we_n;
    logic          sram_oe_n;
    logic [31:0]   perf_if_stall;
    logic [31:0]   perf_mem_stall;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(WAIT), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .perf_if_stall(perf_if_stall), .perf_mem_stall(perf_mem_stall)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'hE3A01005;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Behavioural SRAM attached to the DUT
    logic [31:0] sram_arr [DEPTH];
    logic        sram_init_done = 1'b0;
    always @(posedge clk) begin
        if (!sram_init_done) begin
            for (int i = 0; i < DEPTH; i++) sram_arr[i] <= init_word(i);
            sram_init_done <= 1'b1;
        end else if (sram_we_n === 1'b0) begin
            sram_arr[sram_addr[9:0]] <= sram_wdata;
        end
    end
    assign sram_rdata = sram_arr[sram_addr[9:0]];

    // Bookkeeping
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Staged inputs, applied at the start of the next cycle
    logic        nxt_rst, nxt_if_req, nxt_mem_r, nxt_mem_w;
    logic [31:0] nxt_if_addr, nxt_mem_addr, nxt_mem_wdata;
    bit          rand_mode = 0;
    bit          hold_mem  = 0;

    // Reference model state
    bit          mvalid = 0;
    bit          busy;
    int          g_cyc;
    bit          g_mem, g_write;
    logic [31:0] g_addr, g_data;
    logic [31:0] exp_sram_addr, exp_if_rdata, exp_mem_rdata;
    logic [31:0] exp_perf_if, exp_perf_mem;
    int          starve;
    logic [31:0] ref_mem [DEPTH];

    task automatic model_reset();
        busy = 0; starve = 0; mvalid = 1;
        exp_sram_addr = '0; exp_if_rdata = '0; exp_mem_rdata = '0;
        exp_perf_if = '0; exp_perf_mem = '0;
    endtask

    // One cycle of the reference model: outputs follow from the time of the last
    // grant; a new grant may be made only in a cycle with no transfer in flight.
    task automatic model_cycle();
        bit idle, e_acc, e_done, e_if_rdy, e_mem_rdy, win_mem, any_mem;
        if (!mvalid) begin
            if (rst === 1'b0) model_reset();
            return;
        end
        idle      = !busy;
        e_acc     = busy && (cyc > g_cyc) && (cyc <= g_cyc + WAIT);
        e_done    = busy && (cyc == g_cyc + WAIT + 1);
        e_if_rdy  = e_done && !g_mem;
        e_mem_rdy = e_done && g_mem;
        if (e_done && !g_write) begin
            if (g_mem) exp_mem_rdata = g_data;
            else       exp_if_rdata  = g_data;
        end
        check("if_ready", 32'(if_ready), 32'(e_if_rdy));
        check("mem_ready", 32'(mem_ready), 32'(e_mem_rdy));
        check("sram_oe_n", 32'(sram_oe_n), 32'(!(e_acc && !g_write)));
        check("sram_we_n", 32'(sram_we_n), 32'(!(e_acc && g_write)));
        check("sram_addr", sram_addr, exp_sram_addr);
        if (e_acc && g_write) check("sram_wdata", sram_wdata, g_data);
        check("if_rdata", if_rdata, exp_if_rdata);
        check("mem_rdata", mem_rdata, exp_mem_rdata);
`ifdef ARB_PERF_CNT_EN
        check("perf_if_stall", perf_if_stall, exp_perf_if);
        check("perf_mem_stall", perf_mem_stall, exp_perf_mem);
        if (if_req && !e_if_rdy) exp_perf_if++;
        if ((mem_r_en || mem_w_en) && !e_mem_rdy) exp_perf_mem++;
`else
        check("perf_if_stall", perf_if_stall, 32'd0);
        check("perf_mem_stall", perf_mem_stall, 32'd0);
`endif
        if (e_done) begin
            $display("[TB] cyc %0d %s %s addr=%h data=%h", cyc, g_mem ? "MEM" : "IF",
                     g_write ? "write" : "read", g_addr, g_data);
            busy = 0;
            if (g_mem && !hold_mem) begin nxt_mem_r = 0; nxt_mem_w = 0; end
            if (!g_mem) nxt_if_req = 0;
        end
        if (rst === 1'b0) begin
            model_reset();
        end else if (idle) begin
            any_mem = mem_r_en || mem_w_en;
            win_mem = 0;
            if (if_req || any_mem) begin
                win_mem = any_mem && !(if_req && starve == SL);
                busy    = 1;
                g_cyc   = cyc;
                g_mem   = win_mem;
                g_write = win_mem && mem_w_en;
                g_addr  = win_mem ? mem_addr : if_addr;
                exp_sram_addr = g_addr >> 2;
                if (g_write) begin
                    g_data = mem_wdata;
                    ref_mem[g_addr[11:2]] = mem_wdata;
                end else begin
                    g_data = ref_mem[g_addr[11:2]];
                end
            end
            if (!if_req)      starve = 0;
            else if (win_mem) starve = (starve < SL) ? starve + 1 : SL;
            else              starve = 0;
        end
    endtask

    task automatic rand_stim();
        int op;
        if (!nxt_if_req) begin
            if ($urandom_range(0, 3) == 0) begin
                nxt_if_req  = 1;
                nxt_if_addr = 32'($urandom_range(0, 4095));
            end
        end else if ($urandom_range(0, 63) == 0) begin
            nxt_if_req = 0;
        end
        if (!(nxt_mem_r || nxt_mem_w)) begin
            if ($urandom_range(0, 3) == 0) begin
                op            = int'($urandom_range(0, 2));
                nxt_mem_r     = (op != 1);
                nxt_mem_w     = (op != 0);
                nxt_mem_addr  = 32'($urandom_range(0, 4095));
                nxt_mem_wdata = $urandom();
            end
        end else if ($urandom_range(0, 63) == 0) begin
            nxt_mem_r = 0;
            nxt_mem_w = 0;
        end
        nxt_rst = ($urandom_range(0, 299) != 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rand_mode) rand_stim();
        rst       = nxt_rst;
        if_req    = nxt_if_req;
        if_addr   = nxt_if_addr;
        mem_r_en  = nxt_mem_r;
        mem_w_en  = nxt_mem_w;
        mem_addr  = nxt_mem_addr;
        mem_wdata = nxt_mem_wdata;
        #1;
        model_cycle();
    endtask

    int n, cnt, t0, m_rdy, i_rdy, mem_before, mem_after;
    bit if_seen;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        rst = 0; if_req = 0; if_addr = '0; mem_r_en = 0; mem_w_en = 0;
        mem_addr = '0; mem_wdata = '0;
        nxt_rst = 0; nxt_if_req = 0; nxt_mem_r = 0; nxt_mem_w = 0;
        nxt_if_addr = '0; nxt_mem_addr = '0; nxt_mem_wdata = '0;

        // Reset held with a fetch pending, then the fetch of word 4
        nxt_if_req = 1; nxt_if_addr = 32'h10;
        step(); step();
        nxt_rst = 1;
        step();
        n = 0; cnt = 0;
        while (if_ready !== 1'b1 && n < 10) begin
            step(); n++;
            if (sram_oe_n === 1'b0) cnt++;
        end
        check("rst_release_latency", 32'(n), 32'd3);
        check("if_read_oe_cycles", 32'(cnt), 32'd2);
        check("if_read_data", if_rdata, 32'hE3A01005);

        // Conflict right after a reset so the stall counters start at zero
        step();
        nxt_rst = 0; step(); nxt_rst = 1;
        nxt_if_req = 1; nxt_if_addr = 32'h20;
        nxt_mem_w = 1; nxt_mem_addr = 32'h400; nxt_mem_wdata = 32'hDEADBEEF;
        t0 = cyc + 1; m_rdy = -1; i_rdy = -1; cnt = 0; n = 0;
        while ((m_rdy < 0 || i_rdy < 0) && n < 20) begin
            step(); n++;
            if (sram_we_n === 1'b0) cnt++;
            if (mem_ready === 1'b1 && m_rdy < 0) m_rdy = cyc;
            if (if_ready === 1'b1 && i_rdy < 0) i_rdy = cyc;
        end
        check("conflict_mem_latency", 32'(m_rdy - t0), 32'd3);
        check("conflict_if_latency", 32'(i_rdy - t0), 32'd7);
        check("conflict_we_cycles", 32'(cnt), 32'd2);
`ifdef ARB_PERF_CNT_EN
        check("conflict_perf_mem", perf_mem_stall, 32'd3);
        check("conflict_perf_if", perf_if_stall, 32'd7);
`else
        check("conflict_perf_mem", perf_mem_stall, 32'd0);
        check("conflict_perf_if", perf_if_stall, 32'd0);
`endif
        nxt_mem_r = 1; nxt_mem_addr = 32'h400;
        n = 0;
        do begin step(); n++; end while (mem_ready !== 1'b1 && n < 10);
        check("readback_ready", 32'(mem_ready), 32'd1);
        check("readback_data", mem_rdata, 32'hDEADBEEF);

        // Starvation: MEM requests continuously while IF waits
        hold_mem = 1;
        nxt_mem_r = 1; nxt_mem_addr = 32'h80;
        nxt_if_req = 1; nxt_if_addr = 32'h30;
        mem_before = 0; mem_after = 0; if_seen = 0; n = 0;
        while (mem_after == 0 && n < 60) begin
            step(); n++;
            if (mem_ready === 1'b1) begin
                if (!if_seen) mem_before++;
                else mem_after = 1;
            end
            if (if_ready === 1'b1) if_seen = 1;
        end
        nxt_mem_r = 0; hold_mem = 0;
        check("starve_mem_grants", 32'(mem_before), 32'd3);
        check("starve_mem_after_if", 32'(mem_after), 32'd1);
        repeat (8) step();

        // Reset in the second access cycle of a write
        nxt_mem_w = 1; nxt_mem_addr = 32'h40; nxt_mem_wdata = 32'h12345678;
        step(); step();
        nxt_rst = 0;
        step();
        check("midrst_we_active", 32'(sram_we_n), 32'd0);
        nxt_rst = 1;
        step();
        check("midrst_we_high", 32'(sram_we_n), 32'd1);
        check("midrst_no_ready", 32'(mem_ready), 32'd0);
        n = 0;
        do begin step(); n++; end while (mem_ready !== 1'b1 && n < 10);
        check("midrst_retry_ready", 32'(mem_ready), 32'd1);

        // Randomized traffic with occasional early drops and resets
        rand_mode = 1;
        repeat (1500) step();
        rand_mode = 0;
        nxt_rst = 1; nxt_if_req = 0; nxt_mem_r = 0; nxt_mem_w = 0;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data SRAM between the IF-stage fetch and the MEM-stage load/store of the 5-stage ARM pipeline.
- Arbitrates between the two requesters and sequences a fixed-wait-state SRAM access.
- Returns a one-cycle ready pulse to the winning requester.
- The top level derives pipeline freeze from the ready outputs: a requester with req high and ready low stays frozen.

Parameters:
- ADDR_WIDTH, 32, byte address width on all address ports.
- DATA_WIDTH, 32, word width.
- WAIT_CYCLES, 2, SRAM access cycles per transfer; minimum 1.
- STARVE_LIMIT, 3, consecutive MEM wins allowed while IF is waiting before IF gets forced priority; minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- if_req  in  1  fetch request, held until if_ready.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_rdata  out  DATA_WIDTH  fetched word.
- if_ready  out  1  fetch-complete pulse.
- mem_r_en  in  1  load request, held until mem_ready.
- mem_w_en  in  1  store request, held until mem_ready.
- mem_addr  in  ADDR_WIDTH  load/store address.
- mem_wdata  in  DATA_WIDTH  store data.
- mem_rdata  out  DATA_WIDTH  load data.
- mem_ready  out  1  load/store-complete pulse.
- sram_addr  out  ADDR_WIDTH  word address: latched address >> 2.
- sram_wdata  out  DATA_WIDTH  write data.
- sram_rdata  in  DATA_WIDTH  read data, valid in the final ACCESS cycle.
- sram_we_n  out  1  write strobe, active-low.
- sram_oe_n  out  1  output enable, active-low.
- perf_if_stall  out  32  IF wait-cycle count (feature-gated).
- perf_mem_stall  out  32  MEM wait-cycle count (feature-gated).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-low: when rst=0 at a rising edge, the block resets.
- Reset values:
  - state=IDLE, all counters 0.
  - if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0.
  - sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_wdata=0.
- Reset mid-access aborts the transfer. The strobes are high from the cycle after the reset edge. No ready pulse is issued for the aborted transfer.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any request is pending, grant one requester.
  - At the grant edge, latch the owner, the address, the write data, and write = mem_w_en.
  - Load wait_cnt = WAIT_CYCLES-1 and go to ACCESS.
- ACCESS:
  - sram_oe_n=0 for reads, sram_we_n=0 for writes.
  - sram_addr and sram_wdata come from the latched values and are stable for the whole access.
  - wait_cnt decrements each cycle. At wait_cnt==0, sample sram_rdata into the owner's rdata register (reads only) and go to DONE.
- DONE:
  - Owner's ready=1 for exactly this cycle, strobes high. Next state is IDLE.
  - No back-to-back grant: there is at least one IDLE cycle between transfers.
- Latency: a request seen in IDLE at cycle N gives ready in cycle N+WAIT_CYCLES+1. With defaults, ready arrives in cycle N+3.
- Arbitration in IDLE:
  - MEM wins over IF (the older instruction) unless starve_cnt == STARVE_LIMIT; then IF wins.
  - starve_cnt increments on a MEM grant while if_req=1.
  - starve_cnt clears on an IF grant or whenever if_req=0 in IDLE.
  - starve_cnt saturates at STARVE_LIMIT.
- Simultaneous mem_r_en and mem_w_en: treated as a write.
- A request that drops before ready: the transfer still completes and ready still pulses; the data is discarded.
- rdata registers hold their value until the same requester's next read completes. Writes leave mem_rdata unchanged.
- Address LSBs [1:0] are ignored (word access only).

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - perf_if_stall increments each cycle with if_req=1 and if_ready=0.
  - perf_mem_stall increments each cycle with (mem_r_en|mem_w_en)=1 and mem_ready=0.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: counter logic is absent and both outputs are tied to 0. The port list is unchanged.

Test Plan:
- Reset: hold rst=0 for 2 cycles with if_req=1 -> all outputs at reset values, sram_we_n=1, no ready; release -> if_ready in the 3rd cycle after release.
- IF read: if_req=1, if_addr=0x10, SRAM word 4 = 0xE3A01005 -> sram_addr=4 and sram_oe_n=0 for 2 cycles, if_ready=1 for 1 cycle with if_rdata=0xE3A01005.
- Conflict: if_req and mem_w_en together, mem_addr=0x400, mem_wdata=0xDEADBEEF -> MEM first, sram_we_n=0 for 2 cycles at sram_addr=0x100, mem_ready pulse; IF granted after one IDLE cycle.
- Starvation: if_req=1 with MEM requesting continuously -> exactly 3 MEM grants, then an IF grant, then MEM again.
- Mid-access reset: rst=0 in the 2nd ACCESS cycle of a write -> sram_we_n=1 next cycle, no mem_ready, state IDLE.
- With ARB_PERF_CNT_EN defined, in the Conflict scenario -> perf_mem_stall=3, perf_if_stall=7; without the macro -> both read 0.
